// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, default sizes and byte-merge helper for dmem_sync
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 512;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int DMEM_MAX_W  = 256;
  localparam int DMEM_MAX_BE = DMEM_MAX_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } dmem_state_e;

  // Byte lanes with be[i] set take new_word, the rest keep old_word.
  function automatic logic [DMEM_MAX_W-1:0] be_merge(
    input logic [DMEM_MAX_W-1:0]  old_word,
    input logic [DMEM_MAX_W-1:0]  new_word,
    input logic [DMEM_MAX_BE-1:0] be
  );
    logic [DMEM_MAX_W-1:0] res;
    res = old_word;
    for (int i = 0; i < DMEM_MAX_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_clear_ctrl.sv
// rtl/dmem_clear_ctrl.sv - post-reset clear sequencer for dmem_sync
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ready      : registered, high once every word has been cleared
//   clr_we     : array write strobe for the clear sequence
//   clr_addr   : word address being cleared this cycle
module dmem_clear_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  dmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (state_q == CLEAR) begin
      // The last word is written on this edge, so RUN and ready arrive together.
      if (cnt_q == LAST_ADDR) begin
        state_d = RUN;
        ready_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready    = ready_q;
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/dmem_sync.sv
// rtl/dmem_sync.sv - synchronous data memory with byte-enable writes and write-first bypass
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   ready                            : requests accepted (clear sequence done)
//   rd_en, rd_addr                   : read request
//   rd_data, rd_valid, rd_err        : registered read result, one cycle after request
//   wr_en, wr_addr, wr_data, wr_be   : byte-enabled write request
//   wr_err                           : pulse the cycle after an out-of-range write
module dmem_sync
  import dmem_pkg::*;
#(
  parameter int                 DATA_W     = DMEM_DATA_W,
  parameter int                 DEPTH      = DMEM_DEPTH,
  parameter int                 ADDR_W     = $clog2(DEPTH),
  parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_err,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic                wr_err
);

  localparam int BE_W = DATA_W / 8;
  // One extra bit so the range test also works when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  function automatic logic [DATA_W-1:0] merge_word(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    return DATA_W'(be_merge(DMEM_MAX_W'(old_word), DMEM_MAX_W'(new_word), DMEM_MAX_BE'(be)));
  endfunction

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  dmem_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              rd_in_range, wr_in_range;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] wr_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic              wr_err_q, wr_err_d;

  always_comb begin
    rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
    wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    rd_acc      = ready && rd_en;
    wr_acc      = ready && wr_en && wr_in_range;
    wr_word     = merge_word(mem_q[wr_addr], wr_data, wr_be);

    // Clear writes and user writes never overlap: clr_we is only high while ready is low.
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_word;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = INIT_VALUE;
    end else if (wr_acc) begin
      mem_we    = 1'b1;
    end

    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    rd_err_d   = rd_acc && !rd_in_range;
    if (rd_acc) begin
      if (!rd_in_range) begin
        rd_data_d = '0;
      end else if (wr_acc && (wr_addr == rd_addr)) begin
        // Write-first: return the word as it will be after this edge's write.
        rd_data_d = wr_word;
      end else begin
        rd_data_d = mem_q[rd_addr];
      end
    end

    wr_err_d = ready && wr_en && !wr_in_range;
  end

  // Array contents survive reset; only the clear sequence initialises them.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign wr_err   = wr_err_q;

endmodule

// File: doc/dmem_sync.md
# dmem_sync

Parametrised synchronous data memory for the datapath's load/store stage, replacing the combinational level-sensitive data memory. It has independent read and write ports, byte-enable writes, and registered reads with one-cycle latency. A write-first bypass covers same-address collisions, and a post-reset clear sequence brings every word to a known value before the block accepts requests.

## Interface

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 512, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH) (9), address width in words.
- INIT_VALUE, 0, word value written to every location during the clear sequence.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ready  out  1  high when clear is done and requests are accepted.
- rd_en  in  1  read request, sampled on the rising edge.
- rd_addr  in  ADDR_W  read word address.
- rd_data  out  DATA_W  read result; holds its value until the next accepted read.
- rd_valid  out  1  one-cycle pulse; rd_data is updated this cycle.
- rd_err  out  1  one-cycle pulse together with rd_valid if rd_addr ≥ DEPTH.
- wr_en  in  1  write request, sampled on the rising edge.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
- wr_err  out  1  one-cycle pulse, the cycle after an accepted write with wr_addr ≥ DEPTH.

## Operation

- FSM states: CLEAR and RUN.
  - rst_n low: state = CLEAR, clear counter = 0, array contents are not reset.
  - CLEAR: on each edge, write INIT_VALUE to array[counter], then counter+1.
  - After counter = DEPTH-1 is written, the next state is RUN. RUN persists until reset.
- ready = (state == RUN), registered.
  - rd_en and wr_en are ignored while ready = 0: no array change, no rd_valid, no errors.
- Write, accepted when ready && wr_en && wr_addr < DEPTH:
  - bytes with wr_be[i] = 1 take wr_data bytes; the other bytes keep their old value.
  - wr_be = 0 is a legal no-op.
- Out-of-range write: array unchanged, wr_err pulses.
- Read, accepted when ready && rd_en:
  - next edge: rd_data = array[rd_addr] and rd_valid = 1.
  - out-of-range address: rd_data = 0 and rd_err = 1.
- Collision (accepted read and accepted in-range write on the same edge, same address):
  - rd_data is the post-write word, i.e. the old word merged with wr_data under wr_be (write-first).
- Reads and writes to different addresses are independent, and both ports may be active every cycle.
- Reset mid-operation: outputs clear immediately, the in-flight read is dropped, and the clear sequence restarts from address 0.

## Timing

- Reset values: ready 0, rd_valid 0, rd_err 0, wr_err 0, rd_data 0.
- Clear duration: ready rises on the DEPTH-th rising edge after rst_n deassertion (512 edges by default).
- Read latency: 1 cycle from the accepting edge to rd_valid/rd_data; throughput 1 read per cycle.
- Write: visible to a read issued on the following edge; visible on the same edge via the bypass.
- rd_valid and rd_err are single-cycle pulses; back-to-back reads keep rd_valid high continuously.
- wr_err follows its write by exactly one cycle.

## Structure

- Shared package dmem_pkg:
  - state enum dmem_state_e {CLEAR, RUN};
  - default constants DMEM_DATA_W = 32 and DMEM_DEPTH = 512;
  - function be_merge(old, new, be) returning the byte-merged word, used by both the write path and the bypass.
- One sub-module, dmem_clear_ctrl: owns the FSM and clear counter, and outputs ready, clr_we and clr_addr.
- Top level: muxes clear writes against user writes and holds the array, the read register and the error flags.

## Test plan

- Reset release: count edges until ready -> ready = 1 on edge 512; a read of addresses 0, 255 and 511 returns INIT_VALUE (0) with rd_valid one cycle after the request.
- Byte enables: write 0xDEADBEEF with be = 4'b1111 at address 10, then 0x11223344 with be = 4'b0101 -> read 10 returns 0xDE22BE44.
- Collision: array[20] = 0xAAAAAAAA; on the same edge write 0x55555555 with be = 4'b0011 and read address 20 -> rd_data = 0xAAAA5555 next cycle.
- Range: with DEPTH = 300, write to address 400 -> wr_err pulse, array unchanged; read 400 -> rd_data = 0 with rd_err = 1 and rd_valid = 1.
- Requests during clear: wr_en/rd_en at edge 5 after reset -> no rd_valid, no errors; the address still reads INIT_VALUE after ready.
- Reset mid-run: write 0x12345678 to address 3, pulse rst_n low with a read in flight -> rd_valid stays 0, ready drops, address 3 reads 0 after the re-clear.
